// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences asynchronous SRAM reads/writes for a CPU MAR/MDR interface.
// Optional switch/hex memory-mapped I/O at 16'hFFFF is enabled by defining MEM_ACCESS_MMIO_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  input  logic [15:0] SRAM_DQ_IN,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  output logic [15:0] Hex_Out
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ACT   = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_PULSE = 3'd3;
  localparam logic [2:0] WR_HOLD  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_mmio;
  logic [15:0] r_rdata;
  logic        r_ready;

  logic [2:0]  w_state_d;
  logic [3:0]  w_cnt_d;
  logic        w_capture;
  logic        w_rd_load;
  logic        w_mmio_hit;
  logic [15:0] w_rd_src;
  logic        w_sram_act;
  logic        w_wr_phase;

`ifdef MEM_ACCESS_MMIO_EN
  logic [15:0] r_hex;

  assign w_mmio_hit = (ADDR == 16'hFFFF);
  assign w_rd_src   = r_mmio ? Switches : SRAM_DQ_IN;
  assign Hex_Out    = r_hex;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hex <= 16'h0000;
    end else if (r_state == WR_HOLD && r_mmio) begin
      r_hex <= r_data;
    end
  end
`else
  logic w_unused_switches;

  assign w_mmio_hit        = 1'b0;
  assign w_rd_src          = SRAM_DQ_IN;
  assign Hex_Out           = 16'h0000;
  assign w_unused_switches = ^Switches;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_capture = 1'b0;
    w_rd_load = 1'b0;
    case (r_state)
      IDLE: begin
        // Write wins when both request levels are high.
        if (Mem_WE) begin
          w_state_d = WR_SETUP;
          w_capture = 1'b1;
        end else if (Mem_OE) begin
          w_state_d = RD_ACT;
          w_capture = 1'b1;
        end
      end
      RD_ACT: begin
        if (r_cnt == LP_LAST) begin
          w_state_d = DONE;
          w_cnt_d   = 4'd0;
          w_rd_load = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      WR_SETUP: w_state_d = WR_PULSE;
      WR_PULSE: begin
        if (r_cnt == LP_LAST) begin
          w_state_d = WR_HOLD;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      WR_HOLD: w_state_d = DONE;
      DONE: begin
        if (!Mem_OE && !Mem_WE) begin
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_data  <= 16'h0000;
      r_mmio  <= 1'b0;
      r_rdata <= 16'h0000;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ready <= (w_state_d == DONE) && (r_state != DONE);
      if (w_capture) begin
        r_addr <= ADDR;
        r_data <= Data_from_CPU;
        r_mmio <= w_mmio_hit;
      end
      if (w_rd_load) begin
        r_rdata <= w_rd_src;
      end
    end
  end

  // Strobes decode straight from the async-reset state so reset releases them without a clock.
  assign w_sram_act = !r_mmio && (r_state inside {RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD});
  assign w_wr_phase = !r_mmio && (r_state inside {WR_SETUP, WR_PULSE, WR_HOLD});

  assign SRAM_CE_N   = !w_sram_act;
  assign SRAM_UB_N   = !w_sram_act;
  assign SRAM_LB_N   = !w_sram_act;
  assign SRAM_OE_N   = !(!r_mmio && r_state == RD_ACT);
  assign SRAM_WE_N   = !(!r_mmio && r_state == WR_PULSE);
  assign SRAM_DQ_OE  = w_wr_phase;
  assign SRAM_ADDR   = {4'b0000, r_addr};
  assign SRAM_DQ_OUT = r_data;
  assign Data_to_CPU = r_rdata;
  assign Mem_Ready   = r_ready;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl with an SRAM model and a memory-level reference.
// Exercises the MMIO window too when MEM_ACCESS_MMIO_EN is defined.
module tb_mem_access_ctrl;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] Data_from_CPU = 16'h0000;
  logic [15:0] Switches = 16'h0000;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic [15:0] SRAM_DQ_IN;
  logic [15:0] SRAM_DQ_OUT;
  logic        SRAM_DQ_OE;
  logic [15:0] Hex_Out;

  mem_access_ctrl #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Switches(Switches), .Data_to_CPU(Data_to_CPU),
    .Mem_Ready(Mem_Ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_DQ_IN(SRAM_DQ_IN), .SRAM_DQ_OUT(SRAM_DQ_OUT),
    .SRAM_DQ_OE(SRAM_DQ_OE), .Hex_Out(Hex_Out)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    bit          mmio;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic [15:0] exp_hex;
    int          issue;
    int          lat;
  } txn_t;

  txn_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
  endtask

  // SRAM model: 64K words, default contents derived from the address.
  logic [15:0] sram [0:65535];
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction
  initial for (int i = 0; i < 65536; i++) sram[i] = init_val(16'(i));
  assign SRAM_DQ_IN = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[15:0]] : 16'hDEAD;
  always @(negedge Clk) if (!Reset && !SRAM_CE_N && !SRAM_WE_N) sram[SRAM_ADDR[15:0]] <= SRAM_DQ_OUT;

  // Reference model: what memory and the I/O registers should hold.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_hex = 16'h0000;
  logic [15:0] last_rd = 16'h0000;
  int n_rd_exp = 0, n_wr_exp = 0, n_rd_seen = 0, n_wr_seen = 0;

  function automatic bit is_mmio(input logic [15:0] a);
`ifdef MEM_ACCESS_MMIO_EN
    return a == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Monitor: pops the scoreboard on each Mem_Ready and polices the SRAM bus every cycle.
  int oe_run = 0, we_run = 0;
  txn_t m;
  always @(negedge Clk) begin
    if (Reset) begin
      oe_run = 0;
      we_run = 0;
    end else begin
      if (Mem_Ready) begin
        chk("ready_has_txn", sb.size(), 1);
        if (sb.size() > 0) begin
          m = sb.pop_front();
          chk("latency", cyc - m.issue, m.lat);
          chk("data_to_cpu", Data_to_CPU, m.exp_rd);
          chk("hex_out", Hex_Out, m.exp_hex);
        end
      end
      if (!SRAM_OE_N || !SRAM_WE_N) chk("oe_we_exclusive", !SRAM_OE_N && !SRAM_WE_N, 0);
      if (!SRAM_CE_N) begin
        chk("ub_lb_low", {SRAM_UB_N, SRAM_LB_N}, 0);
        if (sb.size() > 0) begin
          chk("sram_addr", SRAM_ADDR, {4'b0000, sb[0].addr});
          chk("ce_not_mmio", sb[0].mmio, 0);
        end
      end
      if (SRAM_DQ_OE && sb.size() > 0) begin
        chk("dq_oe_on_write", sb[0].wr, 1);
        chk("dq_out", SRAM_DQ_OUT, sb[0].data);
      end
      if (!SRAM_OE_N && sb.size() > 0) chk("oe_on_read_only", sb[0].wr, 0);
      if (!SRAM_OE_N) oe_run++;
      else if (oe_run != 0) begin
        chk("oe_low_cycles", oe_run, W);
        n_rd_seen++;
        oe_run = 0;
      end
      if (!SRAM_WE_N) begin
        we_run++;
        chk("dq_oe_during_we", SRAM_DQ_OE, 1);
      end else if (we_run != 0) begin
        chk("we_low_cycles", we_run, W);
        n_wr_seen++;
        we_run = 0;
      end
    end
  end

  task automatic do_txn(input bit wr, input bit both, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] sw, input int hold, input bit drop_early);
    txn_t t;
    bit got;
    @(posedge Clk); #1;
    Switches = sw;
    ADDR = a;
    Data_from_CPU = d;
    Mem_WE = wr;
    Mem_OE = !wr || both;
    t.wr = wr;
    t.mmio = is_mmio(a);
    t.addr = a;
    t.data = d;
    t.issue = cyc;
    t.lat = wr ? W + 3 : W + 1;
    if (wr) begin
      if (t.mmio) ref_hex = d;
      else begin
        ref_mem[a] = d;
        n_wr_exp++;
      end
      t.exp_rd = last_rd;
    end else begin
      t.exp_rd = t.mmio ? sw : ref_read(a);
      last_rd = t.exp_rd;
      if (!t.mmio) n_rd_exp++;
    end
    t.exp_hex = ref_hex;
    sb.push_back(t);
    // Inputs wander after capture; the transaction must not notice.
    @(posedge Clk); #1;
    ADDR = 16'($urandom);
    Data_from_CPU = 16'($urandom);
    if (drop_early) begin
      Mem_OE = 1'b0;
      Mem_WE = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      if (Mem_Ready) got = 1'b1;
    end
    chk("ready_seen", got, 1);
    if (!got) sb.delete();
    repeat (hold) @(posedge Clk);
    @(posedge Clk); #1;
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
    @(posedge Clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce_n"}, SRAM_CE_N, 1);
    chk({tag, "_oe_n"}, SRAM_OE_N, 1);
    chk({tag, "_we_n"}, SRAM_WE_N, 1);
    chk({tag, "_ub_lb"}, {SRAM_UB_N, SRAM_LB_N}, 2'b11);
    chk({tag, "_dq_oe"}, SRAM_DQ_OE, 0);
    chk({tag, "_addr"}, SRAM_ADDR, 0);
    chk({tag, "_dq_out"}, SRAM_DQ_OUT, 0);
    chk({tag, "_data_to_cpu"}, Data_to_CPU, 0);
    chk({tag, "_ready"}, Mem_Ready, 0);
    chk({tag, "_hex"}, Hex_Out, 0);
  endtask

  initial begin
    bit got;
    #3;
    chk_reset_vals("por");
    @(negedge Clk);
    Reset = 1'b0;

    sram[16'h0030] = 16'h1234;
    ref_mem[16'h0030] = 16'h1234;
    do_txn(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 1, 1'b0);   // read, request held ~4 cycles
    do_txn(1'b1, 1'b0, 16'h0031, 16'hBEEF, 16'h0000, 1, 1'b0);   // write BEEF
    do_txn(1'b0, 1'b0, 16'h0031, 16'h0000, 16'h0000, 0, 1'b0);   // read it back
    do_txn(1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h0000, 0, 1'b0);   // OE+WE -> write
    do_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 7, 1'b0);   // request held 10 cycles
    do_txn(1'b1, 1'b0, 16'h0033, 16'h7777, 16'h0000, 0, 1'b1);   // request dropped mid-write
    do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 0, 1'b0);
    do_txn(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 0, 1'b0);
    do_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'(16'h0030 + $urandom_range(0, 15)),
             16'($urandom), 16'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    // Reset asserted in the middle of the write pulse must release the bus without a clock.
    @(posedge Clk); #1;
    ADDR = 16'h0777;
    Data_from_CPU = 16'h1111;
    Mem_WE = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) got = 1'b1;
    end
    chk("we_low_reached", got, 1);
    #2 Reset = 1'b1;
    #1;
    chk_reset_vals("midwr");
    Mem_WE = 1'b0;
    sb.delete();
    last_rd = 16'h0000;
    ref_hex = 16'h0000;
    @(negedge Clk); #1;
    Reset = 1'b0;

    do_txn(1'b1, 1'b0, 16'h0035, 16'hA1B2, 16'h0000, 0, 1'b0);
    do_txn(1'b0, 1'b0, 16'h0035, 16'h0000, 16'h0000, 0, 1'b0);

    repeat (3) @(posedge Clk);
    chk("queue_drained", sb.size(), 0);
    chk("sram_reads", n_rd_seen, n_rd_exp);
    chk("sram_writes", n_wr_seen, n_wr_exp);
    foreach (ref_mem[a]) chk("sram_content", sram[a], ref_mem[a]);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
